// File: rtl/decoder_in_debounce.sv
// ---------------------------------------------------------------------------
// decoder_in_debounce
//   Debounces a raw, asynchronous pad bus and hands each newly qualified code
//   to a downstream decoder over a single-entry valid/ready holding slot.
//
//   Ports
//     wb_clk_i      in   1      clock, all state on rising edge
//     wb_rst_i      in   1      synchronous active-high reset
//     io_in         in   WIDTH  raw pad value (asynchronous)
//     code_o        out  WIDTH  qualified code for the decoder
//     code_valid_o  out  1      code_o holds an unconsumed code
//     code_ready_i  in   1      downstream accepts code_o this cycle
//     drop_cnt_o    out  8      codes discarded while the slot was full (sat.)
// ---------------------------------------------------------------------------
module decoder_in_debounce #(
    parameter int WIDTH         = 7,
    parameter int STABLE_CYCLES = 4     // 1..255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] code_o,
    output logic             code_valid_o,
    input  logic             code_ready_i,
    output logic [7:0]       drop_cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_e;

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic [7:0]       drop_q, drop_d;
    state_e           state_q, state_d;

    logic same;
    logic qualify;
    logic handshake;

    // Candidate tracking: any change restarts the stability count, so a
    // pulse shorter than STABLE_CYCLES never reaches the threshold.
    always_comb begin
        same   = (sync2_q == cand_q);
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (!same) begin
            cand_d = sync2_q;
            cnt_d  = 8'd1;
        end else if (cnt_q != STABLE) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Comparing against last (not against code_o) makes qualify a one-shot
    // per distinct value, including values that were dropped.
    always_comb begin
        qualify = same && (cnt_q == STABLE) && (cand_q != last_q);
        last_d  = qualify ? cand_q : last_q;
    end

    assign handshake = (state_q == FULL) && code_ready_i;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        drop_d  = drop_q;
        unique case (state_q)
            IDLE: begin
                if (qualify) begin
                    code_d  = cand_q;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (qualify && handshake) begin
                    // Slot frees and refills on the same edge.
                    code_d = cand_q;
                end else if (qualify) begin
                    if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                end else if (handshake) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            code_q  <= '0;
            drop_q  <= '0;
            state_q <= IDLE;
        end else begin
            sync1_q <= io_in;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            code_q  <= code_d;
            drop_q  <= drop_d;
            state_q <= state_d;
        end
    end

    assign code_o       = code_q;
    assign code_valid_o = (state_q == FULL);
    assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_decoder_in_debounce.sv
module tb_decoder_in_debounce;

    localparam int W = 7;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] io  = '0;
    logic         rdy = 1'b0;
    logic [W-1:0] code;
    logic         vld;
    logic [7:0]   drop;

    int n_cmp  = 0;
    int n_fail = 0;

    decoder_in_debounce #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .io_in        (io),
        .code_o       (code),
        .code_valid_o (vld),
        .code_ready_i (rdy),
        .drop_cnt_o   (drop)
    );

    always #5 clk = ~clk;

    // Reference model: a window of the pad values sampled at each edge.
    // A value qualifies when the S+1 samples that have crossed the
    // synchronizer all agree and it differs from the last qualified value.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_last, m_code;
    logic         m_valid;
    int           m_drop;
    bit           m_init = 0;

    always @(posedge clk) begin
        bit           q;
        bit           hs;
        logic [W-1:0] v;
        if (rst) begin
            hist = {};
            repeat (S + 2) hist.push_back('0);
            m_last = '0; m_code = '0; m_valid = 0; m_drop = 0;
            m_init = 1;
        end else if (m_init) begin
            v = hist[hist.size()-2];
            q = 1;
            for (int k = 0; k <= S; k++)
                if (hist[hist.size()-2-k] != v) q = 0;
            if (v == m_last) q = 0;
            hs = m_valid && rdy;
            if (q) begin
                m_last = v;
                if (!m_valid || hs) begin
                    m_code  = v;
                    m_valid = 1;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end else if (hs) begin
                m_valid = 0;
            end
            hist.push_back(io);
            if (hist.size() > S + 2) void'(hist.pop_front());
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        if (m_init && !rst) begin
            chk("model.valid", int'(vld), int'(m_valid));
            chk("model.code",  int'(code), int'(m_code));
            chk("model.drop",  int'(drop), m_drop);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_valid(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (vld) c++;
        end
    endtask

    initial begin
        int c;
        logic [W-1:0] vals[5];
        vals[0] = 7'b0000000; vals[1] = 7'b0000001; vals[2] = 7'b0000011;
        vals[3] = 7'b1111100; vals[4] = 7'b0101010;

        // Reset and all-zero pad: nothing emitted.
        rst = 1; io = '0; rdy = 0;
        step(2);
        rst = 0;
        chk("reset.valid", int'(vld), 0);
        chk("reset.code",  int'(code), 0);
        chk("reset.drop",  int'(drop), 0);
        count_valid(20, c);
        chk("zero.no_emit", c, 0);
        chk("zero.drop", int'(drop), 0);

        // Latency: valid appears after the 7th edge, for one cycle.
        rdy = 1; io = 7'b1111100;
        step(6);
        chk("lat.before", int'(vld), 0);
        step(1);
        chk("lat.valid", int'(vld), 1);
        chk("lat.code",  int'(code), 7'b1111100);
        step(1);
        chk("lat.consumed", int'(vld), 0);
        count_valid(50, c);
        chk("hold.no_reemit", c, 0);

        // Short glitch back to an already emitted value.
        io = 7'b0000001; step(2);
        io = 7'b1111100;
        count_valid(20, c);
        chk("glitch.no_emit", c, 0);
        chk("glitch.drop", int'(drop), 0);

        // Drop while full, then drain.
        io = 7'b0000011; step(10);
        rdy = 0; io = 7'b1111100; step(10);
        chk("full.valid", int'(vld), 1);
        io = 7'b0000011; step(10);
        chk("drop.code", int'(code), 7'b1111100);
        chk("drop.cnt",  int'(drop), 1);
        rdy = 1; step(1);
        chk("drain.idle", int'(vld), 0);
        count_valid(10, c);
        chk("drain.no_reemit", c, 0);

        // Handshake and qualify on the same edge.
        rdy = 0; io = 7'b1111100; step(10);
        io = 7'b0101010; step(6);
        rdy = 1; step(1);
        rdy = 0;
        chk("swap.valid", int'(vld), 1);
        chk("swap.code",  int'(code), 7'b0101010);
        chk("swap.drop",  int'(drop), 1);

        // Two more drops, then reset while full.
        io = 7'b0000011; step(10);
        io = 7'b1111100; step(10);
        chk("pre_rst.drop", int'(drop), 3);
        rst = 1; step(1); rst = 0;
        chk("rst.valid", int'(vld), 0);
        chk("rst.code",  int'(code), 0);
        chk("rst.drop",  int'(drop), 0);

        // Drop counter saturation.
        io = 7'b0000011; step(8);
        for (int i = 0; i < 260; i++) begin
            io = (i % 2 == 0) ? 7'b1111100 : 7'b0000011;
            step(6);
        end
        chk("sat.drop", int'(drop), 255);
        rst = 1; step(1); rst = 0;

        // Randomized segments.
        for (int seg = 0; seg < 600; seg++) begin
            int hold;
            hold = $urandom_range(1, 8);
            io = ($urandom_range(0, 5) == 5) ? W'($urandom) : vals[$urandom_range(0, 4)];
            for (int k = 0; k < hold; k++) begin
                rdy = 1'($urandom);
                rst = ($urandom_range(0, 399) == 0);
                step(1);
            end
            rst = 0;
        end
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_in_debounce.md
DECODER_IN_DEBOUNCE -- requirements
Module: decoder_in_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 7, giving the code width and matching the decoder's io_in width.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, legal range 1..255, giving the consecutive stable cycles needed to qualify a code.
REQ-003 SHALL have port wb_clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port wb_rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port io_in  input  WIDTH  raw pad value, asynchronous to wb_clk_i.
REQ-006 SHALL have port code_o  output  WIDTH  qualified code presented to the downstream decoder.
REQ-007 SHALL have port code_valid_o  output  1  code_o holds an unconsumed code.
REQ-008 SHALL have port code_ready_i  input  1  downstream accepts code_o; transfer when code_valid_o && code_ready_i.
REQ-009 SHALL have port drop_cnt_o  output  8  count of qualified codes discarded while the output was occupied; saturates at 255.

Function
REQ-010 SHALL pass io_in through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-011 SHALL hold a candidate register cand and a stability counter cnt (8 bit); when sync2 != cand: cand <= sync2, cnt <= 1.
REQ-012 SHALL, when sync2 == cand, increment cnt and saturate it at STABLE_CYCLES.
REQ-013 SHALL hold a register last holding the most recently qualified code.
REQ-014 SHALL raise internal qualify for exactly one cycle when cnt == STABLE_CYCLES, sync2 == cand and cand != last; on that edge last <= cand.
REQ-015 SHALL implement FSM IDLE (code_valid_o = 0) and FULL (code_valid_o = 1).
REQ-016 SHALL, in IDLE with qualify: code_o <= cand, go to FULL.
REQ-017 SHALL, in FULL with handshake and no qualify: go to IDLE; code_o holds its value.
REQ-018 SHALL, in FULL with handshake and qualify on the same cycle: code_o <= cand, stay FULL, drop_cnt_o unchanged.
REQ-019 SHALL, in FULL with qualify and no handshake: keep code_o, drop_cnt_o <= min(drop_cnt_o+1, 255); the dropped code is recorded in last and never re-emitted.
REQ-020 SHALL keep code_o stable while code_valid_o = 1 and code_ready_i = 0.
REQ-021 SHALL have a latency, for io_in changing to a new value V != last and then held, such that code_valid_o = 1 with code_o = V after rising edge number STABLE_CYCLES+3 counted from the first edge that samples V (STABLE_CYCLES = 4: 7th edge).
REQ-022 SHALL produce no qualify from any input pulse shorter than STABLE_CYCLES cycles at sync2; the counter restarts on every change.
REQ-023 SHALL emit a value again only after a different value has been qualified in between (A -> B -> A emits A, B, A).
REQ-024 SHALL leave code_ready_i without effect in IDLE.

Reset
REQ-025 SHALL, on wb_rst_i = 1 at a rising edge, clear sync1, sync2, cand, cnt, last, code_o and drop_cnt_o to 0, set code_valid_o to 0 and the FSM to IDLE.
REQ-026 SHALL give reset priority over handshake and qualify on the same edge; reset mid-FULL discards the held code with no drop count.
REQ-027 SHALL never emit an all-zero pad value immediately after reset, because last = 0.

Verification
REQ-028 SHALL pass: reset, io_in = 7'b0000000 for 20 cycles -> code_valid_o stays 0, drop_cnt_o = 0.
REQ-029 SHALL pass: io_in = 7'b1111100 held, code_ready_i = 1 -> code_valid_o high for exactly 1 cycle after the 7th edge with code_o = 7'b1111100, then no re-emission over 50 cycles.
REQ-030 SHALL pass: io_in glitches to 7'b0000001 for 2 cycles then returns to 7'b1111100 (already emitted) -> no emission, drop_cnt_o unchanged.
REQ-031 SHALL pass: code_ready_i = 0, emit 7'b1111100, then 7'b0000011 qualifies -> code_o stays 7'b1111100, drop_cnt_o = 1; then ready = 1 -> one transfer, FSM IDLE.
REQ-032 SHALL pass: FULL with code_ready_i asserted on the same cycle 7'b0101010 qualifies -> code_o = 7'b0101010, code_valid_o stays 1, drop_cnt_o unchanged.
REQ-033 SHALL pass: wb_rst_i pulsed 1 cycle while FULL with drop_cnt_o = 3 -> next cycle code_valid_o = 0, code_o = 0, drop_cnt_o = 0.
